// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared FSM state and mode constants for the bit-serial adder/subtractor
package bit_serial_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_lane.sv
// rtl/bit_serial_lane.sv - one lane: mode/carry registers, full adder and end-of-word flags
module bit_serial_lane
  import bit_serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic accept_i,
  input  logic first_i,
  input  logic last_i,
  input  logic sub_i,
  input  logic a_i,
  input  logic b_i,
  output logic y_o,
  output logic carry_out_o,
  output logic overflow_o
);

  logic mode_q, mode_d;
  logic carry_q, carry_d;
  logic y_q, y_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;

  logic mode_eff, c_in, b_eff, sum, c_next;

  always_comb begin
    // A first slice takes its mode and carry-in from sub, ignoring whatever the previous word left behind.
    mode_eff = first_i ? sub_i : mode_q;
    c_in     = first_i ? sub_i : carry_q;
    b_eff    = b_i ^ (mode_eff == MODE_SUB);
    sum      = a_i ^ b_eff ^ c_in;
    c_next   = (a_i & b_eff) | (a_i & c_in) | (b_eff & c_in);

    mode_d  = mode_q;
    carry_d = carry_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept_i) begin
      mode_d  = mode_eff;
      carry_d = c_next;
      y_d     = sum;
      if (last_i) begin
        cout_d = c_next;
        ovf_d  = c_in ^ c_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      y_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign y_o         = y_q;
  assign carry_out_o = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/bit_serial_addsub.sv
// rtl/bit_serial_addsub.sv - multi-lane word-framed bit-serial adder/subtractor with framing FSM
module bit_serial_addsub
  import bit_serial_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WORD_LEN = 8,
  localparam int CNT_W   = $clog2(WORD_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic [CHANNELS-1:0] sub,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] y,
  output logic                out_valid,
  output logic                out_first,
  output logic                out_last,
  output logic [CHANNELS-1:0] carry_out,
  output logic [CHANNELS-1:0] overflow,
  output logic                frame_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, first_q, last_q, ferr_q;

  logic accept, first_acc, last_acc, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (first_acc) begin
      state_d = ST_RUN;
      cnt_d   = CNT_W'(1);
    end else if (last_acc) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    // Slices arriving in IDLE without in_first are simply not accepted.
    first_acc = in_valid & in_first;
    accept    = first_acc | (in_valid & (state_q == ST_RUN));
    last_acc  = in_valid & ~in_first & (state_q == ST_RUN) &
                (cnt_q == CNT_W'(WORD_LEN - 1));
    ferr_d    = first_acc & (state_q == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= accept;
      first_q <= first_acc;
      last_q  <= last_acc;
      ferr_q  <= ferr_d;
    end
  end

  for (genvar l = 0; l < CHANNELS; l++) begin : g_lane
    bit_serial_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .accept_i   (accept),
      .first_i    (first_acc),
      .last_i     (last_acc),
      .sub_i      (sub[l]),
      .a_i        (a[l]),
      .b_i        (b[l]),
      .y_o        (y[l]),
      .carry_out_o(carry_out[l]),
      .overflow_o (overflow[l])
    );
  end

  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// tb/tb_bit_serial_addsub.sv - directed self-checking bench for bit_serial_addsub
module tb_bit_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_first;
  logic [3:0] sub, a, b;
  logic [3:0] y, carry_out, overflow;
  logic       out_valid, out_first, out_last, frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_serial_addsub #(.CHANNELS(4), .WORD_LEN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .sub(sub), .a(a), .b(b), .y(y), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .carry_out(carry_out),
    .overflow(overflow), .frame_err(frame_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] slice(input logic [31:0] w, input int i);
    return {w[24+i], w[16+i], w[8+i], w[i]};
  endfunction

  // Words packed {lane3, lane2, lane1, lane0}; sub is inverted on non-first slices to prove it is ignored there.
  task automatic run_word(input logic [3:0] sub_v, input logic [31:0] a_w, input logic [31:0] b_w,
                          input logic [31:0] y_w, input logic [3:0] c_exp, input logic [3:0] ov_exp,
                          input bit stall, input bit ferr_exp);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_first = (i == 0);
      sub      = (i == 0) ? sub_v : ~sub_v;
      a        = slice(a_w, i);
      b        = slice(b_w, i);
      @(posedge clk); #1;
      chk1("out_valid", out_valid, 1'b1);
      chk1("out_first", out_first, i == 0);
      chk1("out_last", out_last, i == 7);
      chk1("frame_err", frame_err, (i == 0) ? ferr_exp : 1'b0);
      chk4($sformatf("y_bit%0d", i), y, slice(y_w, i));
      if (i == 7) begin
        chk4("carry_out", carry_out, c_exp);
        chk4("overflow", overflow, ov_exp);
      end
      if (stall && (i == 2 || i == 5)) begin
        int n = $urandom_range(1, 3);
        for (int s = 0; s < n; s++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_first = $urandom_range(0, 1);
          a = 4'($urandom);
          b = 4'($urandom);
          @(posedge clk); #1;
          chk1("stall_valid", out_valid, 1'b0);
          chk4("stall_y_hold", y, slice(y_w, i));
        end
      end
    end
  endtask

  task automatic partial(input int n, input logic [3:0] bits);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_first = (i == 0);
      sub = 4'b0000;
      a = bits;
      b = bits;
      @(posedge clk); #1;
      chk1("partial_last", out_last, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic [3:0] c_exp, input logic [3:0] ov_exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      @(posedge clk); #1;
      chk1("idle_valid", out_valid, 1'b0);
      chk4("carry_hold", carry_out, c_exp);
      chk4("ovf_hold", overflow, ov_exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; sub = '0; a = '0; b = '0;
    #1;
    chk4("rst_y", y, 4'h0);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_first", out_first, 1'b0);
    chk1("rst_last", out_last, 1'b0);
    chk4("rst_carry", carry_out, 4'h0);
    chk4("rst_ovf", overflow, 4'h0);
    chk1("rst_ferr", frame_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Mixed modes: 35+4A, 10-20, 7F+01, 00+00
    run_word(4'b0010, 32'h00_7F_10_35, 32'h00_01_20_4A, 32'h00_80_F0_7F,
             4'b0000, 4'b0100, 1'b0, 1'b0);
    idle(2, 4'b0000, 4'b0100);

    // FF+01 on all lanes, with stalls
    run_word(4'b0000, 32'hFF_FF_FF_FF, 32'h01_01_01_01, 32'h00_00_00_00,
             4'b1111, 4'b0000, 1'b1, 1'b0);
    idle(1, 4'b1111, 4'b0000);

    // Early restart after 3 bits
    partial(3, 4'b1010);
    run_word(4'b0000, 32'h01_01_01_01, 32'h01_01_01_01, 32'h02_02_02_02,
             4'b0000, 4'b0000, 1'b0, 1'b1);
    idle(1, 4'b0000, 4'b0000);

    // Async reset mid-word
    partial(3, 4'b1111);
    #2 rst = 1'b1; in_valid = 1'b0;
    #1;
    chk4("arst_y", y, 4'h0);
    chk1("arst_valid", out_valid, 1'b0);
    chk1("arst_first", out_first, 1'b0);
    chk1("arst_last", out_last, 1'b0);
    chk4("arst_carry", carry_out, 4'h0);
    chk4("arst_ovf", overflow, 4'h0);
    chk1("arst_ferr", frame_err, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b0; a = 4'hF; b = 4'hF; sub = 4'h0;
    @(posedge clk); #1;
    chk1("post_rst_no_first", out_valid, 1'b0);
    chk1("post_rst_no_ferr", frame_err, 1'b0);
    run_word(4'b0010, 32'h00_00_34_12, 32'h00_00_12_34, 32'h00_00_22_46,
             4'b0010, 4'b0000, 1'b0, 1'b0);

    // Back-to-back sub then add on lane 0
    run_word(4'b0001, 32'h00_00_00_05, 32'h00_00_00_03, 32'h00_00_00_02,
             4'b0001, 4'b0000, 1'b0, 1'b0);
    run_word(4'b0000, 32'h00_00_00_05, 32'h00_00_00_03, 32'h00_00_00_08,
             4'b0000, 4'b0000, 1'b0, 1'b0);
    idle(1, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_serial_addsub.md
# bit_serial_addsub

Multi-channel, word-framed bit-serial adder/subtractor. It generalises the single-stream serial adder to CHANNELS parallel lanes. Each lane takes LSB-first operand bit streams under a shared framing/valid handshake, with per-word add/subtract mode, carry reset at word boundaries, and signed-overflow/carry-out flags at word end. It sits between the serialiser front end and the bit-serial accumulator stages of the datapath.

## Interface
- CHANNELS, 4: number of independent lanes (≥1)
- WORD_LEN, 8: bits per word (≥2)
- CNT_W, $clog2(WORD_LEN): bit-counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  the current bit slice on a/b is valid
- in_first  in  1  with in_valid: slice is bit 0 (LSB) of a new word
- sub  in  CHANNELS  per-lane mode, sampled only on a first slice: 0 = a+b, 1 = a−b
- a  in  CHANNELS  operand A bit, one per lane
- b  in  CHANNELS  operand B bit, one per lane
- y  out  CHANNELS  registered sum/difference bit, one per lane
- out_valid  out  1  y is valid
- out_first  out  1  y is bit 0 of a word
- out_last  out  1  y is bit WORD_LEN−1; flags are valid
- carry_out  out  CHANNELS  final carry (sub: 1 = no borrow); valid when out_last
- overflow  out  CHANNELS  two's-complement overflow; valid when out_last
- frame_err  out  1  one-cycle pulse: word aborted by an early in_first

## Operation
- FSM states:
  - IDLE: no word in progress.
  - RUN: bit counter cnt counts 1..WORD_LEN−1.
- Transitions:
  - IDLE→RUN on in_valid & in_first.
  - RUN→IDLE when the slice with cnt==WORD_LEN−1 is accepted.
  - RUN→RUN (restart) on in_valid & in_first before the word completes.
- In IDLE, in_valid without in_first is discarded: no output, no state change.
- Per lane, on an accepted slice:
  - b' = b ^ mode.
  - y = a ^ b' ^ c.
  - Next carry = majority(a, b', c).
  - mode = sub sampled on the first slice, held for the whole word.
- Carry init on a first slice is the incoming sub bit (1 for subtract), not the stored carry. Stored carry is ignored.
- in_valid low is a stall: carry, cnt, mode and state are held; out_valid drops to 0; y holds its last value.
- On the last slice:
  - carry_out = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - Both are registered together with y and out_last.
- Early in_first in RUN:
  - frame_err pulses high in the output cycle of the new first slice.
  - The old word is dropped, with no out_last.
  - The new word starts cleanly at cnt=1.
- No backpressure. The downstream always accepts.

## Timing
- Latency is exactly 1 cycle. The outputs for a slice accepted at edge k are visible after edge k.
- out_first/out_last/out_valid are registered copies of the framing for the same slice.
- Reset values, applied asynchronously:
  - y = 0, out_valid = 0, out_first = 0, out_last = 0, carry_out = 0, overflow = 0, frame_err = 0.
  - State = IDLE, cnt = 0, carries = 0, modes = 0.
- Reset mid-word:
  - The word is abandoned, with no out_last and no frame_err.
  - The first accepted slice after reset must carry in_first.
- carry_out/overflow update only on an out_last cycle. They hold between words.
- A word of WORD_LEN slices with no stalls completes in WORD_LEN cycles. Back-to-back words are allowed with no bubble: a last slice followed by a first slice on the next cycle.

## Structure
- Shared package bit_serial_pkg:
  - FSM state enum (ST_IDLE, ST_RUN).
  - Mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module bit_serial_lane holds one lane's mode, carry and msb-carry registers, plus the full-adder logic. It is instantiated CHANNELS times via generate.
- The framing FSM and bit counter live once in the top.

## Test plan
- WORD_LEN=8, lane0 add: a=0x35, b=0x4A, no stalls → y stream 0x7F LSB-first; out_first on cycle 1, out_last on cycle 8; carry_out=0, overflow=0.
- Lane1 sub: a=0x10, b=0x20 → y=0xF0, carry_out=0 (borrow), overflow=0. Lane2 add: 0x7F+0x01 → y=0x80, overflow=1, carry_out=0 (same word, mixed modes).
- Random stalls (in_valid low 1–3 cycles) inside a word with 0xFF+0x01 → y=0x00, carry_out=1, overflow=0; out_valid low during stalls; result identical to the unstalled run.
- in_first reasserted after 3 bits of a word → frame_err pulses once; no out_last for the aborted word; the new word 0x01+0x01 yields 0x02.
- rst asserted mid-word (async, between edges) → all outputs 0 immediately; a subsequent slice without in_first produces no out_valid; a full word afterwards is correct.
- Back-to-back words, sub then add on the same lane (0x05−0x03, then 0x05+0x03) → 0x02 then 0x08; the carry init differs per word with no bubble.
